pio_audio_pwm: RTL

Memory-mapped PWM audio output responder for the core's data bus, decoded by `simple_interconnect` as one more slave region. The core writes 16-bit signed samples into a small FIFO; the block pops one sample per programmable sample period and drives it as 8-bit PWM onto a GPIO pin. This lets software stream the dry and reverb audio held in ROM to a speaker filter, without cycle-exact CPU timing.

---
 rtl/pio_audio_pwm_pkg.sv | 19 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/pio_audio_pwm.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pio_audio_pwm_pkg.sv
// Shared constants for the PWM audio responder: register offsets,
// CTRL/STATUS bit positions and the minimum effective sample period.
package pio_audio_pwm_pkg;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DIV    = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_FLUSH  = 1;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_UNDERRUN = 2;
    localparam int ST_OVERFLOW = 3;
    localparam int ST_LEVEL    = 16;

    localparam logic [15:0] DIV_MIN = 16'd256;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock sample FIFO with flush; a pop frees a slot for a
// same-cycle push, and flush overrides both.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_pop;
    logic         w_do_push;

    assign level     = r_wptr - r_rptr;
    assign full      = (level == (AW+1)'(DEPTH));
    assign empty     = (level == '0);
    assign rdata     = r_mem[r_rptr[AW-1:0]];
    assign w_do_pop  = pop && !empty && !flush;
    assign w_do_push = push && (!full || w_do_pop) && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/pio_audio_pwm.sv
// Bus-mapped PWM audio output: sample FIFO drained at a programmable
// rate, each sample rendered as 8-bit PWM on a single pin.
module pio_audio_pwm
    import pio_audio_pwm_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [15:0] DIV_RESET = 16'd1134
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        pwm_out,
    output logic        irq
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic        r_en;
    logic [15:0] r_div;
    logic [15:0] r_tick_cnt;
    logic [15:0] r_cur_sample;
    logic [7:0]  r_duty;
    logic [7:0]  r_pwm_cnt;
    logic        r_underrun;
    logic        r_overflow;
    logic [31:0] r_rd;

    logic [1:0]    w_sel;
    logic          w_wr_ctrl;
    logic          w_wr_div;
    logic          w_wr_status;
    logic          w_flush;
    logic          w_push;
    logic          w_pop;
    logic          w_tick;
    logic [15:0]   w_div_eff;
    logic [15:0]   w_fifo_rdata;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;
    logic [31:0]   w_status;
    logic [31:0]   w_rd_next;
    logic          w_unused;

    assign w_sel       = addr[3:2];
    assign w_wr_ctrl   = we && (w_sel == REG_CTRL);
    assign w_wr_div    = we && (w_sel == REG_DIV);
    assign w_wr_status = we && (w_sel == REG_STATUS);
    assign w_flush     = w_wr_ctrl && wd[CTRL_FLUSH];
    assign w_push      = we && (w_sel == REG_DATA) && !w_flush;
    assign w_div_eff   = (r_div < DIV_MIN) ? DIV_MIN : r_div;
    assign w_tick      = r_en && (r_tick_cnt == w_div_eff - 16'd1);
    assign w_pop       = w_tick && !w_empty && !w_flush;
    assign w_unused    = ^{addr[31:4], addr[1:0], wd[31:16]};

    sync_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .wdata (wd[15:0]),
        .rdata (w_fifo_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    always_comb begin
        w_status = '0;
        w_status[ST_EMPTY]       = w_empty;
        w_status[ST_FULL]        = w_full;
        w_status[ST_UNDERRUN]    = r_underrun;
        w_status[ST_OVERFLOW]    = r_overflow;
        w_status[ST_LEVEL +: LW] = w_level;
    end

    always_comb begin
        w_rd_next = '0;
        unique case (w_sel)
            REG_CTRL:   w_rd_next = {31'b0, r_en};
            REG_DIV:    w_rd_next = {16'b0, r_div};
            REG_DATA:   w_rd_next = '0;
            REG_STATUS: w_rd_next = w_status;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en         <= 1'b0;
            r_div        <= DIV_RESET;
            r_tick_cnt   <= '0;
            r_cur_sample <= '0;
            r_duty       <= 8'h80;
            r_pwm_cnt    <= '0;
            r_underrun   <= 1'b0;
            r_overflow   <= 1'b0;
            r_rd         <= '0;
        end else begin
            r_rd <= w_rd_next;
            if (w_wr_ctrl) r_en  <= wd[CTRL_EN];
            if (w_wr_div)  r_div <= wd[15:0];

            if (!r_en || w_wr_div || w_tick) r_tick_cnt <= '0;
            else                              r_tick_cnt <= r_tick_cnt + 16'd1;

            if (w_pop) r_cur_sample <= w_fifo_rdata;

            // Duty only moves at the PWM wrap so a period is never split.
            if (!r_en) begin
                r_pwm_cnt <= '0;
            end else begin
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
                if (r_pwm_cnt == 8'hFF) r_duty <= r_cur_sample[15:8] ^ 8'h80;
            end

            if (w_tick && w_empty)                   r_underrun <= 1'b1;
            else if (w_wr_status && wd[ST_UNDERRUN]) r_underrun <= 1'b0;

            if (w_push && w_full && !w_pop)          r_overflow <= 1'b1;
            else if (w_wr_status && wd[ST_OVERFLOW]) r_overflow <= 1'b0;
        end
    end

    assign rd      = r_rd;
    assign pwm_out = r_en && (r_pwm_cnt < r_duty);
    assign irq     = r_en && (w_level < LW'(DEPTH / 2));
endmodule
